weight_spad: RTL and testbench
==============================

WEIGHT_SPAD -- requirements
Module: weight_spad

Interface
REQ-001 The block SHALL have parameter DATA_BITWIDTH, default 16, meaning the weight word width.
REQ-002 The block SHALL have parameter ADDR_BITWIDTH_SPAD, default 9, meaning the pointer width; it SHALL be at least clog2(KERNEL_SIZE**2)+1.
REQ-003 The block SHALL have parameter KERNEL_SIZE, default 3; storage depth DEPTH = KERNEL_SIZE**2 words.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port w_data_spad, input, DATA_BITWIDTH bits: weight word from the weight router.
REQ-007 The block SHALL have port load_en_spad, input, 1 bit: w_data_spad is valid this cycle.
REQ-008 The block SHALL have port clear, input, 1 bit: discard the stored filter.
REQ-009 The block SHALL have port rd_en, input, 1 bit: PE requests the next weight.
REQ-010 The block SHALL have port rd_data, output, DATA_BITWIDTH bits: weight read out.
REQ-011 The block SHALL have the following 1-bit output ports: rd_valid (rd_data valid), rd_last (last weight of the filter), full (filter completely loaded), ovf_err (sticky flag: write dropped while full), par_err (parity error).
REQ-012 The block SHALL have port wr_count, output, ADDR_BITWIDTH_SPAD bits: number of words stored.

Function
REQ-013 The block SHALL implement states EMPTY, LOAD, FULL and READ.
REQ-014 In EMPTY, when load_en_spad=1 the block SHALL write entry 0, set wr_count=1, and go to LOAD (or go to FULL if DEPTH==1).
REQ-015 In LOAD, each cycle with load_en_spad=1 SHALL write entry wr_count and increment wr_count; the write that brings wr_count to DEPTH SHALL move the block to FULL; cycles with load_en_spad=0 SHALL hold state.
REQ-016 full SHALL be 1 exactly while the state is FULL or READ.
REQ-017 In FULL or READ, load_en_spad=1 SHALL NOT write storage and SHALL set ovf_err=1; ovf_err SHALL be cleared only by reset or clear.
REQ-018 rd_en sampled in FULL or READ SHALL produce the word at rd_ptr on rd_data with rd_valid=1 on the next cycle (1-cycle latency), and SHALL advance rd_ptr; the first such read SHALL move FULL to READ.
REQ-019 The read of entry DEPTH-1 SHALL assert rd_last with rd_valid, wrap rd_ptr to 0, and return the block to FULL; the contents SHALL be retained for reuse.
REQ-020 rd_en in EMPTY or LOAD SHALL be ignored; rd_valid SHALL then be 0 and rd_data SHALL hold its previous value.
REQ-021 rd_valid and rd_last SHALL be single-cycle pulses per accepted rd_en; back-to-back rd_en SHALL give one word per cycle.
REQ-022 clear SHALL take priority over load_en_spad and rd_en in any state: the block SHALL go to EMPTY, wr_count=0, rd_ptr=0, ovf_err=0, rd_valid=0, and same-cycle data SHALL be dropped.

Reset
REQ-023 After reset the block SHALL be in EMPTY with rd_data=0, rd_valid=0, rd_last=0, full=0, ovf_err=0, par_err=0, wr_count=0, rd_ptr=0; storage contents are don't-care.
REQ-024 Reset asserted during LOAD or READ SHALL abort the operation with no further rd_valid pulse.

Configuration
REQ-025 With macro WEIGHT_SPAD_PARITY_EN defined, each entry SHALL store an even-parity bit computed on write, and par_err SHALL pulse alongside rd_valid when the parity recomputed on read mismatches.
REQ-026 Without WEIGHT_SPAD_PARITY_EN, no parity bit SHALL be stored and par_err SHALL be tied to 0; the port list SHALL be identical in both builds.

Structure
REQ-027 Shared package spad_pkg SHALL hold the state enum type and a DEPTH helper function (KERNEL_SIZE**2).
REQ-028 Storage SHALL be a sub-module spad_mem: DEPTH x (DATA_BITWIDTH+parity) register array, one synchronous write port and one synchronous read port.

Verification
REQ-029 Load test: after reset, drive load_en_spad for 9 cycles with data 1..9 -> wr_count reaches 9, full=1 on the cycle after the 9th write.
REQ-030 Read test: in FULL, hold rd_en for 9 cycles -> rd_data 1..9 each with rd_valid=1, starting one cycle after the first rd_en; rd_last=1 only with 9; state returns to FULL; a second pass returns 1..9 again.
REQ-031 Overflow test: in FULL, pulse load_en_spad with 0xFFFF -> ovf_err=1 and the contents are unchanged on re-read.
REQ-032 Gapped load test: data 1..9 with load_en_spad deasserted every other cycle -> all 9 words are stored in order; rd_en during LOAD gives no rd_valid.
REQ-033 Clear/reset test: assert clear together with load_en_spad at wr_count=4 -> EMPTY, wr_count=0, data dropped; assert reset mid-READ -> all outputs return to their reset values.
REQ-034 Parity test (WEIGHT_SPAD_PARITY_EN build): force one storage bit flip on entry 2 -> par_err pulses with that word's rd_valid.

Source files
------------

// File: rtl/spad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spad_pkg
// Description : Shared types and helpers for the weight scratchpad.
//               - spad_state_e : controller state encoding
//               - spad_depth() : storage depth for a KxK filter
// Revision    : 1.0 - initial release
// ============================================================================
package spad_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FULL  = 2'd2,
    ST_READ  = 2'd3
  } spad_state_e;

  function automatic int spad_depth(input int kernel_size);
    return kernel_size * kernel_size;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spad_mem.sv
`default_nettype none
// ============================================================================
// Module      : spad_mem
// Description : DEPTH x DATA_W register array, one synchronous write port and
//               one synchronous read port. The read register clears on reset
//               and holds its value on cycles without a read.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               wr_en/addr/data   - write port
//               rd_en/addr        - read request, data appears next cycle
//               rd_data           - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module spad_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 9,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  // Storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/weight_spad.sv
`default_nettype none
// ============================================================================
// Module      : weight_spad
// Description : Filter-weight scratchpad for a PE. Loads KERNEL_SIZE**2
//               words from the weight router, then replays them to the PE
//               in order (1-cycle read latency), wrapping for reuse.
// Ports       : clk, reset               - clock, sync active-high reset
//               w_data_spad, load_en_spad - weight write stream
//               clear                     - discard stored filter
//               rd_en                     - PE read request
//               rd_data, rd_valid, rd_last- read response
//               full, ovf_err, par_err    - status
//               wr_count                  - words stored
// Options     : WEIGHT_SPAD_PARITY_EN - store an even-parity bit per entry
//               and flag mismatches on par_err (tied 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module weight_spad
  import spad_pkg::*;
#(
  parameter int DATA_BITWIDTH      = 16,
  parameter int ADDR_BITWIDTH_SPAD = 9,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_BITWIDTH-1:0]      w_data_spad,
  input  logic                          load_en_spad,
  input  logic                          clear,
  input  logic                          rd_en,
  output logic [DATA_BITWIDTH-1:0]      rd_data,
  output logic                          rd_valid,
  output logic                          rd_last,
  output logic                          full,
  output logic                          ovf_err,
  output logic                          par_err,
  output logic [ADDR_BITWIDTH_SPAD-1:0] wr_count
);

  localparam int DEPTH  = spad_depth(KERNEL_SIZE);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef WEIGHT_SPAD_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int MEM_W = DATA_BITWIDTH + PAR_BITS;

  localparam logic [ADDR_BITWIDTH_SPAD-1:0] LAST_IDX = ADDR_BITWIDTH_SPAD'(DEPTH - 1);
  localparam logic [ADDR_BITWIDTH_SPAD-1:0] ONE      = ADDR_BITWIDTH_SPAD'(1);

  spad_state_e state_q, state_d;
  logic [ADDR_BITWIDTH_SPAD-1:0] wr_count_q, wr_count_d;
  logic [ADDR_BITWIDTH_SPAD-1:0] rd_ptr_q, rd_ptr_d;
  logic ovf_err_q, ovf_err_d;
  logic rd_valid_q, rd_valid_d;
  logic rd_last_q, rd_last_d;

  logic              mem_we;
  logic              mem_re;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  mem_rdata;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      wr_count_q <= '0;
      rd_ptr_q   <= '0;
      ovf_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_err_q  <= ovf_err_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (load_en_spad) state_d = (DEPTH == 1) ? ST_FULL : ST_LOAD;
        ST_LOAD:  if (load_en_spad && (wr_count_q == LAST_IDX)) state_d = ST_FULL;
        ST_FULL,
        ST_READ:  if (rd_en) state_d = (rd_ptr_q == LAST_IDX) ? ST_FULL : ST_READ;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Datapath / output logic
  // --------------------------------------------------------------------------
  always_comb begin
    wr_count_d = wr_count_q;
    rd_ptr_d   = rd_ptr_q;
    ovf_err_d  = ovf_err_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (clear) begin
      // Same-cycle load/read are dropped.
      wr_count_d = '0;
      rd_ptr_d   = '0;
      ovf_err_d  = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY,
        ST_LOAD: begin
          // wr_count is zero in EMPTY, so it doubles as the write address.
          if (load_en_spad) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count_q + ONE;
          end
        end
        ST_FULL,
        ST_READ: begin
          if (load_en_spad) ovf_err_d = 1'b1;
          if (rd_en) begin
            mem_re     = 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d  = (rd_ptr_q == LAST_IDX);
            rd_ptr_d   = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + ONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef WEIGHT_SPAD_PARITY_EN
  // Even parity: the stored bit makes the XOR of the whole entry zero.
  assign mem_wdata = {^w_data_spad, w_data_spad};
  assign par_err   = rd_valid_q & (^mem_rdata);
`else
  assign mem_wdata = w_data_spad;
  assign par_err   = 1'b0;
`endif

  spad_mem #(
    .DATA_W (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (MEM_AW)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (mem_we),
    .wr_addr (wr_count_q[MEM_AW-1:0]),
    .wr_data (mem_wdata),
    .rd_en   (mem_re),
    .rd_addr (rd_ptr_q[MEM_AW-1:0]),
    .rd_data (mem_rdata)
  );

  assign rd_data  = mem_rdata[DATA_BITWIDTH-1:0];
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign full     = (state_q == ST_FULL) || (state_q == ST_READ);
  assign ovf_err  = ovf_err_q;
  assign wr_count = wr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_spad.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_spad
// Description : Directed self-checking bench for weight_spad (3x3 filter,
//               16-bit words). Inputs change 1ns after a rising edge and
//               outputs are sampled at that same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_spad;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] w_data_spad;
  logic        load_en_spad;
  logic        clear;
  logic        rd_en;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        rd_last;
  logic        full;
  logic        ovf_err;
  logic        par_err;
  logic [8:0]  wr_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_spad #(
    .DATA_BITWIDTH      (16),
    .ADDR_BITWIDTH_SPAD (9),
    .KERNEL_SIZE        (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .w_data_spad  (w_data_spad),
    .load_en_spad (load_en_spad),
    .clear        (clear),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_last      (rd_last),
    .full         (full),
    .ovf_err      (ovf_err),
    .par_err      (par_err),
    .wr_count     (wr_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".rd_data"},  32'(rd_data),  32'h0);
    check({tag, ".rd_valid"}, 32'(rd_valid), 32'h0);
    check({tag, ".rd_last"},  32'(rd_last),  32'h0);
    check({tag, ".full"},     32'(full),     32'h0);
    check({tag, ".ovf_err"},  32'(ovf_err),  32'h0);
    check({tag, ".par_err"},  32'(par_err),  32'h0);
    check({tag, ".wr_count"}, 32'(wr_count), 32'h0);
  endtask

  // Contiguous 9-word load of base+1 .. base+9.
  task automatic load_all(input logic [15:0] base);
    for (int i = 1; i <= 9; i++) begin
      load_en_spad = 1'b1;
      w_data_spad  = base + 16'(i);
      tick();
      check($sformatf("load%0d.wr_count", i), 32'(wr_count), 32'(i));
      check($sformatf("load%0d.full", i), 32'(full), 32'(i == 9));
    end
    load_en_spad = 1'b0;
  endtask

  // Back-to-back read of all 9 entries; expects base+1 .. base+9.
  task automatic read_pass(input string tag, input logic [15:0] base);
    rd_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("%s.rd_valid%0d", tag, k), 32'(rd_valid), 32'h1);
      check($sformatf("%s.rd_data%0d", tag, k), 32'(rd_data), 32'(base + 16'(k)));
      check($sformatf("%s.rd_last%0d", tag, k), 32'(rd_last), 32'(k == 9));
      check($sformatf("%s.par_err%0d", tag, k), 32'(par_err), 32'h0);
    end
    rd_en = 1'b0;
    tick();
    check({tag, ".idle_valid"}, 32'(rd_valid), 32'h0);
    check({tag, ".idle_last"},  32'(rd_last),  32'h0);
    check({tag, ".idle_full"},  32'(full),     32'h1);
    check({tag, ".idle_hold"},  32'(rd_data),  32'(base + 16'd9));
  endtask

  initial begin
    reset        = 1'b1;
    w_data_spad  = '0;
    load_en_spad = 1'b0;
    clear        = 1'b0;
    rd_en        = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check_reset_outputs("reset");

    // Read request in EMPTY is ignored.
    rd_en = 1'b1;
    tick();
    check("empty_rd.valid", 32'(rd_valid), 32'h0);
    check("empty_rd.data",  32'(rd_data),  32'h0);
    rd_en = 1'b0;

    // Contiguous load 1..9, then two full read passes.
    load_all(16'h0);
    read_pass("pass1", 16'h0);
    read_pass("pass2", 16'h0);

    // Overflow: write while FULL is dropped and flagged.
    load_en_spad = 1'b1;
    w_data_spad  = 16'hFFFF;
    tick();
    load_en_spad = 1'b0;
    check("ovf.flag",     32'(ovf_err),  32'h1);
    check("ovf.wr_count", 32'(wr_count), 32'd9);
    check("ovf.full",     32'(full),     32'h1);
    read_pass("ovf_reread", 16'h0);
    check("ovf.sticky", 32'(ovf_err), 32'h1);

    // Clear empties the pad and drops the sticky flag.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr.full",     32'(full),     32'h0);
    check("clr.wr_count", 32'(wr_count), 32'h0);
    check("clr.ovf",      32'(ovf_err),  32'h0);

    // Gapped load A1..A9 with rd_en on the load cycles (must be ignored).
    for (int i = 1; i <= 9; i++) begin
      load_en_spad = 1'b1;
      rd_en        = 1'b1;
      w_data_spad  = 16'h00A0 + 16'(i);
      tick();
      check($sformatf("gap%0d.wr_count", i), 32'(wr_count), 32'(i));
      check($sformatf("gap%0d.no_valid", i), 32'(rd_valid), 32'h0);
      check($sformatf("gap%0d.rd_hold", i),  32'(rd_data),  32'h9);
      load_en_spad = 1'b0;
      rd_en        = 1'b0;
      w_data_spad  = 16'hDEAD;
      tick();
      check($sformatf("gap%0d.hold_cnt", i), 32'(wr_count), 32'(i));
    end
    check("gap.full", 32'(full), 32'h1);
    read_pass("gap_read", 16'h00A0);

    // Clear together with a load at wr_count=4.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      load_en_spad = 1'b1;
      w_data_spad  = 16'h0050 + 16'(i);
      tick();
    end
    check("clr4.pre_count", 32'(wr_count), 32'd4);
    w_data_spad = 16'h0077;
    clear       = 1'b1;
    tick();
    clear        = 1'b0;
    load_en_spad = 1'b0;
    check("clr4.wr_count", 32'(wr_count), 32'h0);
    check("clr4.full",     32'(full),     32'h0);
    tick();
    check("clr4.stay_empty", 32'(wr_count), 32'h0);

    // Reload, then reset in the middle of a READ.
    load_all(16'h0030);
    rd_en = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check("mid.rd_data", 32'(rd_data), 32'h34);
    load_en_spad = 1'b1;
    w_data_spad  = 16'h1234;
    tick();
    load_en_spad = 1'b0;
    check("mid.ovf",     32'(ovf_err), 32'h1);
    check("mid.rd_data5", 32'(rd_data), 32'h35);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outputs("mid_reset");
    tick();
    check("post_reset.no_valid", 32'(rd_valid), 32'h0);
    rd_en = 1'b0;

`ifdef WEIGHT_SPAD_PARITY_EN
    // Corrupt one bit of entry 2; only the third read flags it.
    load_all(16'h0010);
    dut.u_mem.mem_q[2][0] = ~dut.u_mem.mem_q[2][0];
    rd_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check($sformatf("par.valid%0d", k), 32'(rd_valid), 32'h1);
      check($sformatf("par.err%0d", k),   32'(par_err),  32'(k == 3));
    end
    rd_en = 1'b0;
    tick();
    check("par.idle", 32'(par_err), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
